inv_mix_columns: RTL and testbench
==================================

# inv_mix_columns

Byte-serial AES InvMixColumns stage for the decryption datapath. It is the inverse of the encryption-side byte-serial mixColumns. It accepts one state byte per cycle in column-major order (column byte 0..3) over a valid/ready handshake. It accumulates GF(2^8) products per column and streams the transformed column back out one byte per cycle through a separate output buffer, so the next column loads while the previous one drains.

## Interface
- No parameters. Field polynomial (0x1b) and coefficient set fixed.
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid state byte
- in_data  input  8  state byte, column byte order 0,1,2,3; columns 0..3 per 16-byte state
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  out_data holds a valid result byte
- out_data  output  8  InvMixColumns result byte, same order as input
- out_last  output  1  high with out_valid on byte 15 of a 16-byte state
- out_ready  input  1  downstream accepts out_data this cycle

## Operation
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- Coefficients: c[0]=0x0e, c[1]=0x0b, c[2]=0x0d, c[3]=0x09, with multiplication in GF(2^8) mod 0x11b.
- Result: out_r = XOR over k of c[(k−r) mod 4]·b_k.
- Accumulator acc[0..3] (8 bits each), cleared by reset and after each column completes.
- in_cnt (2 bits) gives the byte index k within the current column.
- On input fire with k<3: acc[r] ^= c[(k−r) mod 4]·in_data for all r, then in_cnt++.
- On input fire with k=3:
  - out_buf[r] ← acc[r] ^ c[(3−r) mod 4]·in_data.
  - acc ← 0, in_cnt ← 0.
  - out_full ← 1, out_cnt ← 0.
  - out_col ← in_col, then in_col++ (wraps 3→0).
- Output side: out_valid = out_full, out_data = out_buf[out_cnt], out_last = out_full && out_cnt==3 && out_col==3.
- On output fire: out_cnt++. At out_cnt==3, out_full ← 0 and out_cnt ← 0.
- in_ready = !(in_cnt==3 && out_full). Bytes 0..2 of the next column are always accepted. Byte 3 stalls until the buffer has drained; there is no same-cycle pass-through.
- out_data holds its last value while out_valid is low or out_ready is low. It is stable under backpressure.
- Byte 3 can never be accepted while out_full=1, so a buffer overwrite is impossible.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0x00, in_ready=1, all counters 0, acc=0, out_buf=0.
- Reset mid-column or mid-drain discards all partial data. The first byte after reset is column 0, byte 0.
- Latency: 4th byte accepted at edge t → out_valid=1 with byte 0 in cycle t+1. Bytes 1..3 follow in t+2..t+4 with out_ready held high.
- Sustained throughput with both sides always ready: 4 bytes per 5 cycles. Byte 3 of the next column is accepted in cycle t+5.
- in_ready depends only on registered state. It has no combinational path from out_ready or in_valid.
- in_valid dropping mid-column simply pauses accumulation, with no timeout.

## Structure
- Shared AES package: the coefficient constants 0x0e/0x0b/0x0d/0x09, the reduction constant 0x1b, and the byte/column width constants.
- Four instances of the existing ffMult multiplier, one per coefficient, all fed by in_data.
- The product for each acc[r] is selected by (in_cnt−r) mod 4.
- No new sub-module. Counters, accumulator, and output buffer stay in this module.

## Test plan
- Reset, then one column 8e 4d a1 bc, out_ready=1 → out bytes db 13 53 45 in cycles t+1..t+4, out_last=0.
- Columns d5 d5 d7 d6 then 9f dc 58 9d, back-to-back → d4 d4 d4 d5, f2 0a 22 5c. in_ready low exactly one cycle, on byte 3 of column 2.
- Full 16-byte state: four columns of 01 01 01 01, c6 c6 c6 c6, and two repeats of the above → identity for the constant columns. out_last high only on the 16th output byte. Column count wraps 3→0 for the next state.
- out_ready held low for 10 cycles after the first column → out_data stays db and out_valid stays 1. The next column's bytes 0..2 are accepted and byte 3 stalls. On release, output resumes with no loss or duplication.
- Random in_valid/out_ready gaps over 64 random columns → output matches a reference InvMixColumns model byte-exact. MixColumns then inv_mix_columns round-trips to the original.
- rst asserted after 2 bytes of a column and again during a drain → outputs go to reset values next cycle. A subsequent clean column 8e 4d a1 bc yields db 13 53 45.

Source files
------------

// File: rtl/inv_mix_columns_pkg.sv
// Shared AES constants for the byte-serial decryption datapath.
// Holds the GF(2^8) reduction constant, the InvMixColumns coefficient set
// and the byte/column width constants used by inv_mix_columns and ffMult.
package inv_mix_columns_pkg;

  localparam int BYTE_W    = 8;
  localparam int COL_BYTES = 4;
  localparam int CNT_W     = 2;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [CNT_W-1:0]  idx_t;

  // Low byte of the field polynomial x^8 + x^4 + x^3 + x + 1 (0x11b).
  localparam byte_t GF_POLY = 8'h1b;

  localparam byte_t INV_C0 = 8'h0e;
  localparam byte_t INV_C1 = 8'h0b;
  localparam byte_t INV_C2 = 8'h0d;
  localparam byte_t INV_C3 = 8'h09;

  // Coefficient applied to byte k when accumulating into output row r,
  // indexed by (k - r) mod 4.
  function automatic byte_t inv_coef(input idx_t idx);
    case (idx)
      2'd0:    inv_coef = INV_C0;
      2'd1:    inv_coef = INV_C1;
      2'd2:    inv_coef = INV_C2;
      default: inv_coef = INV_C3;
    endcase
  endfunction

endpackage

// File: rtl/ffMult.sv
// ffMult: combinational GF(2^8) multiplier, p = a * b mod 0x11b.
// Ports:
//   a - multiplicand byte
//   b - multiplier byte (tied to a constant coefficient by the caller)
//   p - product byte
module ffMult
  import inv_mix_columns_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] p
);

  logic [BYTE_W-1:0] a_sh;
  logic [BYTE_W-1:0] p_acc;

  // Shift-and-add: a_sh walks through a*x^i, reduced by the field
  // polynomial every time a bit falls off the top.
  always_comb begin
    a_sh  = a;
    p_acc = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) begin
        p_acc = p_acc ^ a_sh;
      end
      a_sh = {a_sh[BYTE_W-2:0], 1'b0} ^ (a_sh[BYTE_W-1] ? GF_POLY : 8'h00);
    end
  end

  assign p = p_acc;

endmodule

// File: rtl/inv_mix_columns.sv
// inv_mix_columns: byte-serial AES InvMixColumns.
// Accepts one state byte per cycle (column-major, byte 0..3 per column),
// accumulates the GF(2^8) products of each column and hands the finished
// column to a separate output buffer, so the next column loads while the
// previous one drains.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - in_data carries a state byte
//   in_data    - state byte
//   in_ready   - byte accepted this cycle when in_valid is high
//   out_valid  - out_data carries a result byte
//   out_data   - InvMixColumns result byte, same order as the input
//   out_last   - marks byte 15 of a 16-byte state
//   out_ready  - downstream takes out_data this cycle
module inv_mix_columns
  import inv_mix_columns_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  logic [BYTE_W-1:0] acc_reg     [COL_BYTES];
  logic [BYTE_W-1:0] out_buf_reg [COL_BYTES];
  logic [BYTE_W-1:0] prod        [COL_BYTES];
  logic [BYTE_W-1:0] acc_next    [COL_BYTES];
  logic [CNT_W-1:0]  in_cnt_reg;
  logic [CNT_W-1:0]  in_col_reg;
  logic [CNT_W-1:0]  out_cnt_reg;
  logic [CNT_W-1:0]  out_col_reg;
  logic              out_full_reg;
  logic              in_fire;
  logic              out_fire;
  logic              col_done;

  // One multiplier per coefficient; every accumulator row picks the
  // product matching its distance from the current byte index.
  generate
    for (genvar gi = 0; gi < COL_BYTES; gi++) begin : g_row
      logic [CNT_W-1:0] sel;

      ffMult u_mult (
        .a (in_data),
        .b (inv_coef(CNT_W'(gi))),
        .p (prod[gi])
      );

      assign sel          = in_cnt_reg - CNT_W'(gi);
      assign acc_next[gi] = acc_reg[gi] ^ prod[sel];
    end
  endgenerate

  // Byte 3 may only enter once the buffer is empty; bytes 0..2 only touch
  // the accumulator and are always accepted.
  assign in_ready  = !((in_cnt_reg == 2'd3) && out_full_reg);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_full_reg && out_ready;
  assign col_done  = in_fire && (in_cnt_reg == 2'd3);

  assign out_valid = out_full_reg;
  assign out_data  = out_buf_reg[out_cnt_reg];
  assign out_last  = out_full_reg && (out_cnt_reg == 2'd3) && (out_col_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < COL_BYTES; r++) begin
        acc_reg[r]     <= '0;
        out_buf_reg[r] <= '0;
      end
      in_cnt_reg   <= '0;
      in_col_reg   <= '0;
      out_cnt_reg  <= '0;
      out_col_reg  <= '0;
      out_full_reg <= 1'b0;
    end else begin
      if (out_fire) begin
        if (out_cnt_reg == 2'd3) begin
          out_full_reg <= 1'b0;
          out_cnt_reg  <= '0;
        end else begin
          out_cnt_reg <= out_cnt_reg + 2'd1;
        end
      end

      // A column can only complete while the buffer is empty, so this
      // never collides with the drain update above.
      if (col_done) begin
        for (int r = 0; r < COL_BYTES; r++) begin
          out_buf_reg[r] <= acc_next[r];
          acc_reg[r]     <= '0;
        end
        in_cnt_reg   <= '0;
        out_full_reg <= 1'b1;
        out_cnt_reg  <= '0;
        out_col_reg  <= in_col_reg;
        in_col_reg   <= in_col_reg + 2'd1;
      end else if (in_fire) begin
        for (int r = 0; r < COL_BYTES; r++) begin
          acc_reg[r] <= acc_next[r];
        end
        in_cnt_reg <= in_cnt_reg + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns.sv
module tb_inv_mix_columns;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  always #5 clk = ~clk;

  inv_mix_columns dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   col_idx    = 0;
  int   stall_cnt  = 0;
  int   ready_mode = 1;  // 0 = hold low, 1 = high, 2 = random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x = a;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Column packed as {b0,b1,b2,b3}; row r = xor_k m[(k-r) mod 4] * b_k.
  function automatic logic [31:0] col_mul(input logic [31:0] c, input logic [31:0] m);
    logic [7:0]  b  [4];
    logic [7:0]  mm [4];
    logic [7:0]  o;
    logic [31:0] res = 32'h0;
    for (int k = 0; k < 4; k++) begin
      b[k]  = c[31-8*k -: 8];
      mm[k] = m[31-8*k -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      o = 8'h00;
      for (int k = 0; k < 4; k++) o ^= gmul(mm[(k - r + 4) % 4], b[k]);
      res[31-8*r -: 8] = o;
    end
    return res;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    return col_mul(c, 32'h0e0b0d09);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    return col_mul(c, 32'h02030101);
  endfunction

  task automatic expect_col(input logic [31:0] e);
    exp_t x;
    for (int r = 0; r < 4; r++) begin
      x.d = e[31-8*r -: 8];
      x.l = (col_idx == 3) && (r == 3);
      q.push_back(x);
    end
    col_idx = (col_idx + 1) % 4;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n = 0;
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_col(input logic [31:0] c, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(c[31-8*k -: 8], max_gap);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    col_idx = 0;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_in_ready"},  in_ready,  1);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: every output handshake pops one expected byte.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", out_data, 32'hffff_ffff);
      end else begin
        e = q.pop_front();
        $display("out byte %02h last=%0b (expected %02h last=%0b)", out_data, out_last, e.d, e.l);
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
      end
    end
    if (!rst && in_valid && !in_ready) stall_cnt++;
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    do_reset("reset");

    // Single column and its latency.
    expect_col(32'hdb135345);
    send_col(32'h8e4da1bc, 0);
    for (int i = 0; i < 4; i++) begin
      chk("latency_valid", out_valid, 1);
      @(negedge clk);
    end
    chk("after_drain_valid", out_valid, 0);
    drain();

    // Two back-to-back columns: exactly one stall cycle on byte 3 of the second.
    stall_cnt = 0;
    expect_col(32'hd4d4d4d5);
    expect_col(32'hf20a225c);
    send_col(32'hd5d5d7d6, 0);
    send_col(32'h9fdc589d, 0);
    drain();
    chk("stall_cycles", stall_cnt, 1);

    // Backpressure: output frozen, next column's byte 3 held off.
    ready_mode = 0;
    @(negedge clk);
    expect_col(32'hdb135345);
    send_col(32'h8e4da1bc, 0);
    expect_col(32'hd4d4d4d5);
    send_byte(8'hd5, 0);
    send_byte(8'hd5, 0);
    send_byte(8'hd7, 0);
    in_valid = 1'b1;
    in_data  = 8'hd6;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data",  out_data,  8'hdb);
      chk("bp_in_ready",  in_ready,  0);
      @(negedge clk);
    end
    ready_mode = 1;
    begin
      int n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("bp_release_timeout", 0, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Full 16-byte state from column 0, then one more to show the wrap.
    do_reset("reset_state");
    expect_col(32'h01010101);
    expect_col(32'hc6c6c6c6);
    expect_col(32'hdb135345);
    expect_col(32'hd4d4d4d5);
    expect_col(32'hdb135345);
    send_col(32'h01010101, 0);
    send_col(32'hc6c6c6c6, 0);
    send_col(32'h8e4da1bc, 0);
    send_col(32'hd5d5d7d6, 0);
    send_col(32'h8e4da1bc, 0);
    drain();

    // Random gaps on both sides: model check, then MixColumns round trip.
    ready_mode = 2;
    for (int i = 0; i < 32; i++) begin
      y = $urandom();
      expect_col(inv_col(y));
      send_col(y, 3);
    end
    for (int i = 0; i < 32; i++) begin
      x = $urandom();
      expect_col(x);
      send_col(mix_col(x), 3);
    end
    drain();
    ready_mode = 1;

    // Reset mid-column, then mid-drain, then a clean column.
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset("reset_mid_col");
    ready_mode = 0;
    @(negedge clk);
    expect_col(32'hdb135345);
    send_col(32'h8e4da1bc, 0);
    chk("pre_reset_full", out_valid, 1);
    do_reset("reset_mid_drain");
    ready_mode = 1;
    @(negedge clk);
    expect_col(32'hdb135345);
    send_col(32'h8e4da1bc, 0);
    drain();
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
